// File: rtl/axi_window_pkg.sv
// Shared AXI response/burst codes and the read-slave FSM state type.
package axi_window_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_rd_skid_fifo.sv
// Two-entry valid/ready buffer with fall-through when empty: zero added latency.
// in_rdy drops only when both entries hold data; output holds steady while out_rdy is low.
module axi_rd_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] ent0, ent1;
  logic             push, pop;

  assign in_rdy  = (count != 2'd2);
  assign out_vld = (count != 2'd0) || in_vld;
  assign out_dat = (count != 2'd0) ? ent0 : in_dat;
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      case (count)
        2'd0: begin
          // An input consumed in the same cycle bypasses storage entirely.
          if (push && !pop) begin
            ent0  <= in_dat;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            ent0 <= in_dat;
          end else if (push) begin
            ent1  <= in_dat;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            ent0  <= ent1;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/axi_window_read_slave.sv
// AXI read slave over a window RAM; first beat 2 cycles after AR, 1 beat/cycle under rready.
// Optional AXI_WINDOW_READ_SLAVE_STATS_EN adds saturating burst/error counters.
module axi_window_read_slave
  import axi_window_pkg::*;
#(
  parameter int DATA_BYTE_WIDTH    = 32,
  parameter int DATA_BYTE_SHIFT    = 5,
  parameter int WINDOW_DEPTH_INDEX = 7,
  parameter int WINDOW_DEPTH       = 100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    s_axi_arid,
  input  logic [31:0]                   s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [3:0]                    s_axi_rid,
  output logic [DATA_BYTE_WIDTH*8-1:0]  s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic                          mem_rd_en,
  output logic [WINDOW_DEPTH_INDEX-1:0] mem_rd_addr,
  input  logic [DATA_BYTE_WIDTH*8-1:0]  mem_rd_data,
  output logic                          busy
`ifdef AXI_WINDOW_READ_SLAVE_STATS_EN
  ,
  output logic [15:0]                   stat_bursts,
  output logic [15:0]                   stat_errors
`endif
);

  localparam int DW = DATA_BYTE_WIDTH * 8;
  localparam int PW = 4 + 2 + 1 + DW;

  rd_state_t   state, state_n;
  logic [3:0]  b_id, p_id;
  logic [7:0]  b_len, beat_cnt;
  logic        b_fixed, b_err;
  logic [31:0] idx;
  logic        p_vld, p_err, p_last;
  logic [1:0]  fifo_cnt;
  logic        fifo_in_rdy;
  logic [PW-1:0] fifo_in, fifo_out;
  logic        ar_hs, issue, beat_bad, last_issue, room;

  assign s_axi_arready = (state == IDLE) && !rst;
  assign ar_hs         = s_axi_arvalid && s_axi_arready;
  // Full-width index so addresses past the RAM's index range still count as out of window.
  assign beat_bad      = b_err || (idx >= 32'(WINDOW_DEPTH));
  assign last_issue    = (beat_cnt == b_len);
  assign room          = fifo_in_rdy && (({1'b0, fifo_cnt} + {2'b00, p_vld}) < 3'd2);
  assign busy          = (state != IDLE);
  assign mem_rd_addr   = idx[WINDOW_DEPTH_INDEX-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    issue     = 1'b0;
    mem_rd_en = 1'b0;
    case (state)
      IDLE: if (ar_hs) state_n = BURST;
      BURST: begin
        if (room) begin
          issue     = 1'b1;
          mem_rd_en = !beat_bad;
          if (last_issue) state_n = DRAIN;
        end
      end
      DRAIN: if (s_axi_rvalid && s_axi_rready && s_axi_rlast) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_id     <= '0;
      b_len    <= '0;
      b_fixed  <= 1'b0;
      b_err    <= 1'b0;
      idx      <= '0;
      beat_cnt <= '0;
      p_vld    <= 1'b0;
      p_err    <= 1'b0;
      p_last   <= 1'b0;
      p_id     <= '0;
    end else begin
      p_vld  <= issue;
      p_err  <= issue && beat_bad;
      p_last <= issue && last_issue;
      if (issue) p_id <= b_id;
      if (ar_hs) begin
        b_id     <= s_axi_arid;
        b_len    <= s_axi_arlen;
        b_fixed  <= (s_axi_arburst == BURST_FIXED);
        b_err    <= !burst_supported(s_axi_arburst) ||
                    (s_axi_arsize != 3'(DATA_BYTE_SHIFT));
        idx      <= s_axi_araddr >> DATA_BYTE_SHIFT;
        beat_cnt <= 8'd0;
      end else if (issue) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (!b_fixed) idx <= idx + 32'd1;
      end
    end
  end

  // Error beats never read the RAM and return zero data.
  assign fifo_in = {p_id, (p_err ? RESP_SLVERR : RESP_OKAY), p_last,
                    ((p_vld && !p_err) ? mem_rd_data : {DW{1'b0}})};

  axi_rd_skid_fifo #(.WIDTH(PW)) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (p_vld),
    .in_rdy  (fifo_in_rdy),
    .in_dat  (fifo_in),
    .out_vld (s_axi_rvalid),
    .out_rdy (s_axi_rready),
    .out_dat (fifo_out),
    .count   (fifo_cnt)
  );

  assign {s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata} = fifo_out;

`ifdef AXI_WINDOW_READ_SLAVE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bursts <= '0;
      stat_errors <= '0;
    end else begin
      if (ar_hs && (stat_bursts != 16'hFFFF)) stat_bursts <= stat_bursts + 16'd1;
      if (s_axi_rvalid && s_axi_rready && (s_axi_rresp == RESP_SLVERR) &&
          (stat_errors != 16'hFFFF))
        stat_errors <= stat_errors + 16'd1;
    end
  end
`endif

endmodule

// File: doc/axi_window_read_slave.md
AXI_WINDOW_READ_SLAVE -- requirements
Module: axi_window_read_slave

Interface
REQ-001 SHALL have parameter DATA_BYTE_WIDTH, default 32, bytes per beat (rdata width = DATA_BYTE_WIDTH*8).
REQ-002 SHALL have parameter DATA_BYTE_SHIFT, default 5, log2(DATA_BYTE_WIDTH); byte address to window index shift.
REQ-003 SHALL have parameter WINDOW_DEPTH_INDEX, default 7, window index width.
REQ-004 SHALL have parameter WINDOW_DEPTH, default 100, number of valid windows.
REQ-005 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_axi_arid  in  4  read ID
- s_axi_araddr  in  32  byte address
- s_axi_arlen  in  8  beats minus 1
- s_axi_arsize  in  3  beat size
- s_axi_arburst  in  2  burst type
- s_axi_arvalid  in  1  address valid
- s_axi_arready  out  1  address accept
- s_axi_rid  out  4  echoed ID
- s_axi_rdata  out  DATA_BYTE_WIDTH*8  beat data
- s_axi_rresp  out  2  response
- s_axi_rlast  out  1  last beat
- s_axi_rvalid  out  1  data valid
- s_axi_rready  in  1  data accept
- mem_rd_en  out  1  window RAM read strobe
- mem_rd_addr  out  WINDOW_DEPTH_INDEX  window index
- mem_rd_data  in  DATA_BYTE_WIDTH*8  RAM data, valid 1 cycle after mem_rd_en
- busy  out  1  burst in progress

Function
REQ-006 SHALL use FSM states IDLE, BURST, DRAIN: IDLE->BURST on arvalid&&arready; BURST->DRAIN after last mem read issued; DRAIN->IDLE on final rvalid&&rready.
REQ-007 SHALL assert arready only in IDLE; one outstanding burst, no interleaving.
REQ-008 SHALL latch arid, arlen, arburst, arsize and start index = araddr>>DATA_BYTE_SHIFT on handshake; low address bits ignored.
REQ-009 SHALL issue first mem_rd_en in cycle after handshake; first rvalid two cycles after handshake.
REQ-010 SHALL sustain one beat per cycle while rready high, via 2-entry output buffer; mem_rd_en issued only if buffer occupancy plus in-flight reads < 2.
REQ-011 SHALL never drop or duplicate a beat; rdata/rresp/rlast/rid stable while rvalid&&!rready.
REQ-012 SHALL increment index per beat for INCR (01); hold index for FIXED (00).
REQ-013 SHALL return SLVERR (2'b10) on every beat of a burst with arburst WRAP/reserved or arsize != DATA_BYTE_SHIFT; beat count still arlen+1.
REQ-014 SHALL, for beat index >= WINDOW_DEPTH (incl. index overflow past 2^WINDOW_DEPTH_INDEX), suppress mem_rd_en, drive rdata 0, rresp SLVERR; other beats OKAY (2'b00).
REQ-015 SHALL assert rlast exactly on beat arlen+1; arlen=0 gives single beat with rlast.
REQ-016 SHALL drive busy high from handshake cycle+1 until final beat accepted.

Reset
REQ-017 SHALL on rst force IDLE, empty buffer, cancel in-flight reads; arready=0 while rst high, 1 first cycle after release.
REQ-018 SHALL reset rvalid, rlast, mem_rd_en, busy to 0; rid, rresp, rdata, mem_rd_addr to 0.
REQ-019 SHALL on rst mid-burst abandon burst with no further beats after release.

Configuration
REQ-020 SHALL with AXI_WINDOW_READ_SLAVE_STATS_EN defined add outputs stat_bursts[15:0] (accepted bursts) and stat_errors[15:0] (SLVERR beats accepted), saturating, reset 0; without it, ports and counters absent, behaviour otherwise identical.

Structure
REQ-021 SHALL place AXI resp codes (OKAY, SLVERR), burst codes (FIXED, INCR, WRAP) and FSM state enum in shared package axi_window_pkg.
REQ-022 SHALL implement output buffer as sub-module axi_rd_skid_fifo (2-entry, valid/ready both sides).

Verification
REQ-023 INCR araddr=0x40, arlen=3, rready=1 -> 4 beats, indices 2,3,4,5, consecutive cycles, rlast on beat 4, rresp 00.
REQ-024 arlen=7, rready toggled 1/0 each cycle -> 8 beats in order, data stable while stalled, none lost.
REQ-025 INCR araddr=0xC40 (index 98), arlen=3 -> beats 98,99 OKAY; beats 100,101 SLVERR, rdata 0, no mem_rd_en.
REQ-026 arburst=2'b10, arlen=1 -> 2 SLVERR beats, rlast on second, arready back high after.
REQ-027 FIXED araddr=0x20, arlen=2 -> 3 beats all index 1; arid=4'hA echoed on all.
REQ-028 rst pulsed after beat 2 of arlen=7 -> rvalid 0 immediately, arready 1 cycle after release, no stale beats.
